uart_temp_rx: RTL

UART_TEMP_RX -- requirements
Module: uart_temp_rx

---
 rtl/uart_temp_pkg.sv | 24 ++
 rtl/uart_rx_byte.sv | 97 +++++++++
 rtl/uart_temp_rx.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_temp_pkg.sv
// Shared constants, FSM state types and the ASCII hex decoder for the UART
// temperature-message receiver.
package uart_temp_pkg;

  localparam int         CLKS_PER_BIT_DEF = 434;
  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam int         HEX_DIGITS       = 6;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;
  typedef enum logic [1:0] {HEX, CR_SEEN, SYNC}      prs_state_t;

  // Returns {is_hex, nibble}; only upper-case A-F count as hex.
  function automatic logic [4:0] hex_decode(input logic [7:0] ch);
    logic [4:0] res;
    res = 5'b0;
    if (ch >= 8'h30 && ch <= 8'h39)
      res = {1'b1, ch[3:0]};
    else if (ch >= 8'h41 && ch <= 8'h46)
      res = {1'b1, ch[3:0] + 4'd9};
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchronizer, mid-bit sampling bit FSM,
// one-cycle byte strobe or frame-error pulse after the stop sample.
//
//   state | meaning
//   IDLE  | line idle, waiting for a synchronized low
//   START | half-bit wait, confirms the start bit
//   DATA  | sampling 8 data bits, LSB first
//   STOP  | sampling the stop bit
module uart_rx_byte
  import uart_temp_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       strobe,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

  bit_state_t    state;
  logic          sync_q1, sync_q2;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1   <= 1'b1;
      sync_q2   <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      strobe    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_q1   <= rx;
      sync_q2   <= sync_q1;
      strobe    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!sync_q2) begin
            state <= START;
            cnt   <= HALF_LOAD;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!sync_q2) begin
              state   <= DATA;
              cnt     <= BIT_LOAD;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg   <= {sync_q2, shreg[7:1]};
            cnt     <= BIT_LOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            // Back to IDLE on the sample itself so a following start bit is not missed.
            state <= IDLE;
            if (sync_q2) begin
              data   <= shreg;
              strobe <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_temp_rx.sv
// Receives "HHHHHH\r\n" hex count messages over UART and publishes the value.
// Optional saturating error counter enabled by macro UART_TEMP_RX_ERR_CNT_EN.
//
//   state   | meaning
//   HEX     | collecting up to six hex digits, then expecting CR
//   CR_SEEN | six digits and CR received, expecting LF
//   SYNC    | after an error, discarding bytes until LF
module uart_temp_rx
  import uart_temp_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx_i,
  output logic [23:0] data_o,
  output logic        data_valid_o,
  output logic        frame_err_o,
  output logic        parse_err_o
`ifdef UART_TEMP_RX_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt_o
`endif
);

  localparam logic [2:0] ND_FULL = 3'(HEX_DIGITS);

  logic [7:0]  byte_data;
  logic        byte_strobe;
  logic        byte_frame_err;
  logic [4:0]  dec;
  logic        byte_bad;
  prs_state_t  state;
  logic [2:0]  nd;
  logic [23:0] acc;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (uart_rx_i),
    .data      (byte_data),
    .strobe    (byte_strobe),
    .frame_err (byte_frame_err)
  );

  assign frame_err_o = byte_frame_err;
  assign dec         = hex_decode(byte_data);

  always_comb begin
    byte_bad = 1'b0;
    case (state)
      HEX:     byte_bad = !((dec[4] && nd < ND_FULL) || (byte_data == ASCII_CR && nd == ND_FULL));
      CR_SEEN: byte_bad = (byte_data != ASCII_LF);
      default: byte_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HEX;
      nd           <= '0;
      acc          <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      parse_err_o  <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      parse_err_o  <= 1'b0;
      if (byte_frame_err) begin
        state <= SYNC;
        nd    <= '0;
      end else if (byte_strobe) begin
        if (byte_bad) begin
          parse_err_o <= 1'b1;
          nd          <= '0;
          state       <= SYNC;
        end else begin
          case (state)
            HEX: begin
              if (dec[4]) begin
                acc <= {acc[19:0], dec[3:0]};
                nd  <= nd + 3'd1;
              end else begin
                state <= CR_SEEN;
              end
            end
            CR_SEEN: begin
              data_o       <= acc;
              data_valid_o <= 1'b1;
              nd           <= '0;
              state        <= HEX;
            end
            SYNC: begin
              if (byte_data == ASCII_LF) begin
                nd    <= '0;
                state <= HEX;
              end
            end
            default: state <= SYNC;
          endcase
        end
      end
    end
  end

`ifdef UART_TEMP_RX_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      err_cnt_o <= '0;
    else if ((frame_err_o || parse_err_o) && err_cnt_o != 8'hFF)
      err_cnt_o <= err_cnt_o + 8'd1;
  end
`endif

endmodule
